uart_rx_frontend: RTL

Oversampling UART receive front-end that sits directly upstream of the RX FIFO inside the uart top level. It synchronises the asynchronous i_rx line and validates the start bit. It recovers DataLength data bits LSB-first by 3-sample majority vote, checks the stop bit, and pushes each good byte into the RX FIFO with a single-cycle write strobe. Framing and overrun errors are reported as single-cycle pulses for the status register.

---
 rtl/uart_rx_frontend.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frontend.sv
// UART receive front-end: 2-flop line sync, 3-sample majority vote per bit,
// stop-bit check, FIFO write strobe plus framing/overrun pulses.
module uart_rx_frontend #(
    parameter int unsigned DataLength = 8,
    parameter int unsigned OverSample = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_baud_tick,
    input  logic                  i_rx,
    input  logic                  i_fifo_full,
    output logic [DataLength-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_frame_err,
    output logic                  o_overrun,
    output logic                  o_busy
);

    localparam int unsigned CW = (OverSample > 1) ? $clog2(OverSample) : 1;
    localparam int unsigned BW = $clog2(DataLength + 1);
    localparam logic [CW-1:0] CntLast = CW'(OverSample - 1);
    localparam logic [CW-1:0] SampA   = CW'(OverSample / 2 - 1);
    localparam logic [CW-1:0] SampB   = CW'(OverSample / 2);
    localparam logic [CW-1:0] SampC   = CW'(OverSample / 2 + 1);
    localparam logic [BW-1:0] BitLast = BW'(DataLength - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_e;

    logic rst_meta_q, rst_q;
    logic rx_meta_q, rx_s_q;

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [DataLength-1:0]   sh_q, sh_d;
    logic                    sa_q, sa_d;
    logic                    sb_q, sb_d;
    logic [DataLength-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    logic                    ovr_q, ovr_d;

    logic maj, decide, wrap;

    // Assert asynchronously, release two clocks after i_rst drops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rst_meta_q <= 1'b1;
            rst_q      <= 1'b1;
        end else begin
            rst_meta_q <= 1'b0;
            rst_q      <= rst_meta_q;
        end
    end

    always_ff @(posedge i_clk or posedge rst_q) begin
        if (rst_q) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign maj    = (sa_q & sb_q) | (sa_q & rx_s_q) | (sb_q & rx_s_q);
    assign decide = (cnt_q == SampC);
    assign wrap   = (cnt_q == CntLast);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        if (i_baud_tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (cnt_q == SampA) sa_d = rx_s_q;
            if (cnt_q == SampB) sb_d = rx_s_q;
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx_s_q) state_d = START;
                end
                START: begin
                    if (decide && maj) begin
                        state_d = IDLE;
                    end else if (wrap) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
                DATA: begin
                    if (decide) sh_d = DataLength'({maj, sh_q} >> 1);
                    if (wrap) begin
                        if (bit_q == BitLast) state_d = STOP;
                        else bit_d = bit_q + 1'b1;
                    end
                end
                STOP: begin
                    if (decide) begin
                        if (!maj) begin
                            ferr_d  = 1'b1;
                            state_d = BRK;
                        end else if (i_fifo_full) begin
                            ovr_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = sh_q;
                            state_d = IDLE;
                        end
                    end
                end
                BRK: begin
                    // A held-low line must go high before another start.
                    cnt_d = '0;
                    if (rx_s_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge rst_q) begin
        if (rst_q) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sa_q    <= 1'b1;
            sb_q    <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
    assign o_busy      = (state_q != IDLE);

endmodule
